// File: rtl/writeback_unit.sv
// Writeback unit: two DEPTH-entry result queues (ALU, MEM), round-robin arbitrated into one
// registered register-file write port. Define WB_SCOREBOARD_EN to drive the BUSY pending-write bitmap.
module writeback_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADD_WIDTH = 5,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned NU_REG    = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ALU_VALID,
  input  logic [ADD_WIDTH-1:0] ALU_RD,
  input  logic [WIDTH-1:0]     ALU_DATA,
  output logic                 ALU_READY,
  input  logic                 MEM_VALID,
  input  logic [ADD_WIDTH-1:0] MEM_RD,
  input  logic [WIDTH-1:0]     MEM_DATA,
  output logic                 MEM_READY,
  output logic                 WRITE_ENABLE,
  output logic [ADD_WIDTH-1:0] ADDRESS_3,
  output logic [WIDTH-1:0]     WRITE_DATA,
  output logic [NU_REG-1:0]    BUSY
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    CH_ALU = 1'b0,
    CH_MEM = 1'b1
  } chan_e;

  logic [ADD_WIDTH-1:0] q_rd_q   [2][DEPTH];
  logic [WIDTH-1:0]     q_data_q [2][DEPTH];
  logic [PW-1:0]        wr_ptr_q [2];
  logic [PW-1:0]        wr_ptr_d [2];
  logic [PW-1:0]        rd_ptr_q [2];
  logic [PW-1:0]        rd_ptr_d [2];
  logic [CW-1:0]        cnt_q    [2];
  logic [CW-1:0]        cnt_d    [2];

  chan_e                last_q, last_d;
  logic                 we_q, we_d;
  logic [ADD_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;

  logic [1:0]           in_valid;
  logic [ADD_WIDTH-1:0] in_rd   [2];
  logic [WIDTH-1:0]     in_data [2];
  logic [1:0]           ready, push, pop, nonempty;
  logic [ADD_WIDTH-1:0] head_rd   [2];
  logic [WIDTH-1:0]     head_data [2];

  assign in_valid   = {MEM_VALID, ALU_VALID};
  assign in_rd[0]   = ALU_RD;
  assign in_rd[1]   = MEM_RD;
  assign in_data[0] = ALU_DATA;
  assign in_data[1] = MEM_DATA;

  // Ready and nonempty come from registered counts only: a full queue refuses
  // a push even while popping, and a fresh push is never popped the same edge.
  always_comb begin
    ready    = '0;
    push     = '0;
    nonempty = '0;
    for (int unsigned c = 0; c < 2; c++) begin
      ready[c]     = cnt_q[c] < CW'(DEPTH);
      push[c]      = in_valid[c] & ready[c];
      nonempty[c]  = cnt_q[c] != '0;
      head_rd[c]   = q_rd_q[c][rd_ptr_q[c]];
      head_data[c] = q_data_q[c][rd_ptr_q[c]];
    end
  end

  always_comb begin
    pop    = '0;
    last_d = last_q;
    if (nonempty[0] && (!nonempty[1] || last_q == CH_MEM)) begin
      pop[0] = 1'b1;
      last_d = CH_ALU;
    end else if (nonempty[1]) begin
      pop[1] = 1'b1;
      last_d = CH_MEM;
    end
  end

  // RD==0 entries still load address/data but never strobe the write.
  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (pop[0]) begin
      we_d    = head_rd[0] != '0;
      addr_d  = head_rd[0];
      wdata_d = head_data[0];
    end else if (pop[1]) begin
      we_d    = head_rd[1] != '0;
      addr_d  = head_rd[1];
      wdata_d = head_data[1];
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < 2; c++) begin
      wr_ptr_d[c] = push[c] ? wr_ptr_q[c] + PW'(1) : wr_ptr_q[c];
      rd_ptr_d[c] = pop[c]  ? rd_ptr_q[c] + PW'(1) : rd_ptr_q[c];
      cnt_d[c]    = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      last_q  <= CH_MEM;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      for (int unsigned c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge CLK) begin
    for (int unsigned c = 0; c < 2; c++) begin
      if (push[c]) begin
        q_rd_q[c][wr_ptr_q[c]]   <= in_rd[c];
        q_data_q[c][wr_ptr_q[c]] <= in_data[c];
      end
    end
  end

  assign ALU_READY    = ready[0];
  assign MEM_READY    = ready[1];
  assign WRITE_ENABLE = we_q;
  assign ADDRESS_3    = addr_q;
  assign WRITE_DATA   = wdata_q;

`ifdef WB_SCOREBOARD_EN
  logic [PW-1:0]     slot_off [2][DEPTH];
  logic [NU_REG-1:0] busy;

  // A slot is live when its distance past the read pointer is below the count.
  always_comb begin
    busy = '0;
    for (int unsigned c = 0; c < 2; c++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_off[c][i] = PW'(i) - rd_ptr_q[c];
        for (int unsigned r = 1; r < NU_REG; r++) begin
          if (({1'b0, slot_off[c][i]} < cnt_q[c]) && (32'(q_rd_q[c][i]) == r)) begin
            busy[r] = 1'b1;
          end
        end
      end
    end
    for (int unsigned r = 1; r < NU_REG; r++) begin
      if (we_q && (32'(addr_q) == r)) begin
        busy[r] = 1'b1;
      end
    end
  end

  assign BUSY = busy;
`else
  assign BUSY = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized + directed bench for writeback_unit against a queue-based reference model and scoreboard.
module tb_writeback_unit;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int D  = 2;
  localparam int NR = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          ALU_VALID, MEM_VALID;
  logic [AW-1:0] ALU_RD, MEM_RD;
  logic [W-1:0]  ALU_DATA, MEM_DATA;
  logic          ALU_READY, MEM_READY;
  logic          WRITE_ENABLE;
  logic [AW-1:0] ADDRESS_3;
  logic [W-1:0]  WRITE_DATA;
  logic [NR-1:0] BUSY;

  always #5 CLK = ~CLK;

  writeback_unit #(
    .WIDTH    (W),
    .ADD_WIDTH(AW),
    .DEPTH    (D),
    .NU_REG   (NR)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ALU_VALID   (ALU_VALID),
    .ALU_RD      (ALU_RD),
    .ALU_DATA    (ALU_DATA),
    .ALU_READY   (ALU_READY),
    .MEM_VALID   (MEM_VALID),
    .MEM_RD      (MEM_RD),
    .MEM_DATA    (MEM_DATA),
    .MEM_READY   (MEM_READY),
    .WRITE_ENABLE(WRITE_ENABLE),
    .ADDRESS_3   (ADDRESS_3),
    .WRITE_DATA  (WRITE_DATA),
    .BUSY        (BUSY)
  );

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [W-1:0]  data;
  } ent_t;

  ent_t          aq[$], mq[$], exp_q[$];
  bit            last_is_mem, m_we, acc_a, acc_m;
  logic [AW-1:0] exp_addr;
  logic [W-1:0]  exp_data;
  int unsigned   checks = 0, passes = 0;
  int unsigned   mcount;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: one edge of the writeback unit, pop decided from pre-edge contents.
  task automatic model_step();
    ent_t e;
    bit   take_a, take_m, rdy_a, rdy_m;
    if (RESET) begin
      aq.delete(); mq.delete();
      last_is_mem = 1'b1; m_we = 1'b0; acc_a = 1'b0; acc_m = 1'b0;
      exp_addr = '0; exp_data = '0;
      return;
    end
    rdy_a = aq.size() < D;
    rdy_m = mq.size() < D;
    acc_a = ALU_VALID && rdy_a;
    acc_m = MEM_VALID && rdy_m;
    take_a = aq.size() > 0 && (mq.size() == 0 || last_is_mem);
    take_m = !take_a && mq.size() > 0;
    m_we = 1'b0;
    if (take_a || take_m) begin
      e = take_a ? aq.pop_front() : mq.pop_front();
      last_is_mem = take_m;
      exp_addr = e.rd;
      exp_data = e.data;
      m_we = e.rd != 0;
      if (m_we) exp_q.push_back(e);
    end
    if (acc_a) aq.push_back('{rd: ALU_RD, data: ALU_DATA});
    if (acc_m) mq.push_back('{rd: MEM_RD, data: MEM_DATA});
  endtask

`ifdef WB_SCOREBOARD_EN
  function automatic logic [NR-1:0] model_busy();
    logic [NR-1:0] b = '0;
    foreach (aq[i]) if (aq[i].rd != 0) b[aq[i].rd] = 1'b1;
    foreach (mq[i]) if (mq[i].rd != 0) b[mq[i].rd] = 1'b1;
    if (m_we) b[exp_addr] = 1'b1;
    return b;
  endfunction
`endif

  task automatic check_outputs();
    chk("alu_ready", ALU_READY, aq.size() < D);
    chk("mem_ready", MEM_READY, mq.size() < D);
    chk("write_enable", WRITE_ENABLE, m_we);
    chk("address_hold", ADDRESS_3, exp_addr);
    chk("data_hold", WRITE_DATA, exp_data);
`ifdef WB_SCOREBOARD_EN
    chk("busy", BUSY, model_busy());
`else
    chk("busy_zero", BUSY, '0);
`endif
  endtask

  task automatic tick();
    check_outputs();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ALU_VALID = 1'b0; MEM_VALID = 1'b0;
    ALU_RD = '0; MEM_RD = '0; ALU_DATA = '0; MEM_DATA = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  always @(negedge CLK) begin
    ent_t e;
    if (WRITE_ENABLE === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_write", WRITE_ENABLE, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", ADDRESS_3, e.rd);
        chk("wr_data", WRITE_DATA, e.data);
      end
    end
  end

  initial begin
    idle_inputs();
    RESET = 1'b1;
    model_step(); @(posedge CLK); #1;
    model_step(); @(posedge CLK); #1;
    RESET = 1'b0;
    chk("rst_we", WRITE_ENABLE, 1'b0);
    chk("rst_addr", ADDRESS_3, 0);
    chk("rst_data", WRITE_DATA, 0);
    chk("rst_alu_ready", ALU_READY, 1'b1);
    chk("rst_mem_ready", MEM_READY, 1'b1);
    chk("rst_busy", BUSY, 0);

    // Single ALU write: strobe only in the cycle after the second edge.
    ALU_VALID = 1'b1; ALU_RD = 5'd5; ALU_DATA = 32'h0000_00AA;
    tick();
    ALU_VALID = 1'b0;
    chk("single_no_bypass", WRITE_ENABLE, 1'b0);
    tick();
    chk("single_we", WRITE_ENABLE, 1'b1);
    chk("single_addr", ADDRESS_3, 5);
    chk("single_data", WRITE_DATA, 32'hAA);
    tick();
    chk("single_we_off", WRITE_ENABLE, 1'b0);

    // Simultaneous pushes alternate ALU then MEM, twice.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      ALU_VALID = 1'b1; ALU_RD = 5'd1; ALU_DATA = 32'h11;
      MEM_VALID = 1'b1; MEM_RD = 5'd2; MEM_DATA = 32'h22;
      tick();
      idle_inputs();
      tick();
      chk("rr_first", ADDRESS_3, 1);
      tick();
      chk("rr_second", ADDRESS_3, 2);
      tick();
    end

    // RD 0 is consumed without a strobe.
    ALU_VALID = 1'b1; ALU_RD = 5'd0; ALU_DATA = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    tick();
    chk("rd0_we", WRITE_ENABLE, 1'b0);
    chk("rd0_data", WRITE_DATA, 32'hDEAD_BEEF);
    chk("rd0_ready", ALU_READY, 1'b1);

    // MEM backpressure under continuous traffic, data 1,2,3 in order.
    ALU_VALID = 1'b1; ALU_RD = 5'd3; ALU_DATA = 32'd100;
    MEM_VALID = 1'b1; MEM_RD = 5'd4; MEM_DATA = 32'd1;
    mcount = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (acc_a) ALU_DATA = ALU_DATA + 1;
      if (acc_m) begin
        if (mcount < 3) begin mcount++; MEM_DATA = mcount; end
        else MEM_VALID = 1'b0;
      end
    end
    chk("bp_all_mem_accepted", MEM_VALID, 1'b0);
    idle_inputs();
    repeat (6) tick();

    // Reset with two entries queued discards them.
    ALU_VALID = 1'b1; ALU_RD = 5'd9; ALU_DATA = 32'h99;
    MEM_VALID = 1'b1; MEM_RD = 5'd10; MEM_DATA = 32'hAA55;
    tick();
    do_reset();
    chk("mid_rst_we", WRITE_ENABLE, 1'b0);
    chk("mid_rst_addr", ADDRESS_3, 0);
    chk("mid_rst_data", WRITE_DATA, 0);
    chk("mid_rst_alu_ready", ALU_READY, 1'b1);
    chk("mid_rst_mem_ready", MEM_READY, 1'b1);
    repeat (4) tick();

    // Random traffic, producers hold offers until accepted.
    for (int k = 0; k < 600; k++) begin
      if (!ALU_VALID || acc_a) begin
        ALU_VALID = $urandom_range(0, 99) < 65;
        ALU_RD    = AW'($urandom_range(0, 31));
        ALU_DATA  = $urandom;
      end
      if (!MEM_VALID || acc_m) begin
        MEM_VALID = $urandom_range(0, 99) < 65;
        MEM_RD    = AW'($urandom_range(0, 31));
        MEM_DATA  = $urandom;
      end
      tick();
    end
    idle_inputs();
    repeat (6) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter WIDTH, default 32, data width of results and register-file write data.
REQ-002 Parameter ADD_WIDTH, default 5, destination register address width.
REQ-003 Parameter DEPTH, default 2, entries per input queue (power of two, >= 2).
REQ-004 Parameter NU_REG, default 32, number of architectural registers.
REQ-005 CLK  input  1  global clock; one clock, all state updates on its rising edge.
REQ-006 RESET  input  1  global reset; synchronous and active-high.
REQ-007 ALU_VALID  input  1  ALU result offered.
REQ-008 ALU_RD  input  ADD_WIDTH  ALU destination register.
REQ-009 ALU_DATA  input  WIDTH  ALU result value.
REQ-010 ALU_READY  output  1  ALU queue can accept.
REQ-011 MEM_VALID  input  1  load result offered.
REQ-012 MEM_RD  input  ADD_WIDTH  load destination register.
REQ-013 MEM_DATA  input  WIDTH  load result value.
REQ-014 MEM_READY  output  1  MEM queue can accept.
REQ-015 WRITE_ENABLE  output  1  register-file write strobe.
REQ-016 ADDRESS_3  output  ADD_WIDTH  register-file write address.
REQ-017 WRITE_DATA  output  WIDTH  register-file write data.
REQ-018 BUSY  output  NU_REG  per-register pending-write bitmap (see Configuration).

Function
REQ-019 Each channel SHALL own a DEPTH-entry FIFO of {RD, DATA}; a transfer occurs on an edge where VALID && READY.
REQ-020 READY SHALL equal (queue count < DEPTH), computed from registered count only; a full queue refuses a push even when popped that cycle.
REQ-021 Push and pop on the same queue in one cycle SHALL leave the count unchanged and preserve FIFO order; pointers wrap modulo DEPTH.
REQ-022 At most one entry SHALL be popped per cycle across both queues.
REQ-023 Arbitration SHALL be round-robin: one nonempty queue -> that queue; both nonempty -> the queue not granted on the most recent grant; LAST_GRANT updates only on a grant.
REQ-024 WRITE_ENABLE, ADDRESS_3, WRITE_DATA SHALL be registered: the entry popped at edge N drives them during the cycle after edge N; the register file captures it at edge N+1.
REQ-025 An entry pushed at edge N SHALL be poppable no earlier than edge N+1 (no same-cycle bypass).
REQ-026 A popped entry with RD == 0 SHALL be consumed with WRITE_ENABLE = 0 that cycle; ADDRESS_3/WRITE_DATA still load the entry.
REQ-027 When no entry is popped, WRITE_ENABLE SHALL be 0 and ADDRESS_3/WRITE_DATA SHALL hold their previous values.
REQ-028 VALID with READY = 0 SHALL have no effect; the producer holds RD/DATA stable until accepted.

Reset
REQ-029 While RESET = 1 at an edge: both queues empty, LAST_GRANT = MEM (so ALU wins first tie), WRITE_ENABLE = 0, ADDRESS_3 = 0, WRITE_DATA = 0, BUSY = 0; ALU_READY/MEM_READY = 1 after the reset edge.
REQ-030 Reset mid-operation SHALL discard all queued entries; no write strobe issues from pre-reset entries.

Configuration
REQ-031 Macro WB_SCOREBOARD_EN: defined -> BUSY[r] = 1 iff any queued entry (either queue) or the currently driven output with WRITE_ENABLE = 1 targets r, r != 0; BUSY[0] is always 0.
REQ-032 WB_SCOREBOARD_EN undefined -> BUSY tied to all zeros; no scoreboard logic instantiated; all other behaviour identical.

Verification
REQ-033 Reset then single ALU push {RD=5, DATA=0x0000_00AA} at edge 1 -> WRITE_ENABLE=1, ADDRESS_3=5, WRITE_DATA=0xAA during the cycle after edge 2 only.
REQ-034 ALU {RD=1,0x11} and MEM {RD=2,0x22} pushed same edge -> writes in order RD=1 then RD=2 on consecutive cycles; repeat -> RD=1 then RD=2 again (strict alternation).
REQ-035 Hold MEM_VALID for 3 pushes with DEPTH=2 and both queues blocked by continuous traffic -> MEM_READY=0 after 2 accepts; third accepted only after a pop; data order 0x1,0x2,0x3 preserved.
REQ-036 ALU push {RD=0, DATA=0xDEAD_BEEF} -> entry consumed, WRITE_ENABLE stays 0, ALU_READY restored.
REQ-037 Two entries queued, RESET=1 for one edge -> no WRITE_ENABLE pulse afterwards, both READY=1, outputs 0.
REQ-038 With WB_SCOREBOARD_EN: push MEM {RD=7} -> BUSY[7]=1 from the cycle after push through the cycle WRITE_ENABLE=1 for RD=7, 0 the following cycle; without the macro BUSY=0 throughout.
